// File: rtl/systolic_output_deskew.sv
// Output de-skew stage for a systolic array.
// The array emits each result row on a diagonal: lane i of a row arrives
// i accepted beats after lane 0. Lane i is delayed by LANES-1-i beats so that
// every lane of a row lines up at the delay-line outputs on the same beat.
// The aligned row is registered into word_o. One tile of ROWS rows is
// framed per start_i.
//
// Handshake: valid_i qualifies skew_i. There is no back-pressure. A cycle
// with valid_i=0 is a stall, and every delay stage and the beat counter hold.
// valid_o is a one-cycle qualifier for word_o. word_o holds its last value
// while valid_o is low.
module systolic_output_deskew #(
    parameter  int DATA_WIDTH = 16,
    parameter  int LANES      = 8,
    parameter  int ROWS       = 8,
    localparam int WORD_WIDTH = DATA_WIDTH * LANES
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  valid_i,
    input  logic [WORD_WIDTH-1:0] skew_i,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic                  valid_o,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CW = $clog2(ROWS + LANES);
    // Last beat index of the fill phase, and last beat index of the whole tile.
    localparam logic [CW-1:0] FILL_LAST   = CW'((LANES >= 2) ? (LANES - 2) : 0);
    localparam logic [CW-1:0] STREAM_LAST = CW'(ROWS + LANES - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    shift_en;
    logic                    fire;
    logic                    fire_last;
    logic [WORD_WIDTH-1:0]   aligned;
    logic [WORD_WIDTH-1:0]   word_q;
    logic                    valid_q;
    logic                    last_q;
    logic                    done_q;

    // The delay lines advance only on beats that are accepted inside a tile.
    assign shift_en = valid_i && (state_q != IDLE);

    // Build one delay line per lane. The top lane is taken straight from the input.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if (i < LANES - 1) begin : g_dly
            localparam int D = LANES - 1 - i;
            logic [DATA_WIDTH-1:0] sr_q [D];

            // Shift register: stage 0 takes the new beat; the oldest value sits in stage D-1.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int j = 0; j < D; j++) sr_q[j] <= '0;
                end else if (shift_en) begin
                    sr_q[0] <= skew_i[i*DATA_WIDTH +: DATA_WIDTH];
                    for (int j = 1; j < D; j++) sr_q[j] <= sr_q[j-1];
                end
            end

            assign aligned[i*DATA_WIDTH +: DATA_WIDTH] = sr_q[D-1];
        end else begin : g_direct
            assign aligned[i*DATA_WIDTH +: DATA_WIDTH] = skew_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Next-state logic: frame the tile, count accepted beats, and flag output rows.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fire      = 1'b0;
        fire_last = 1'b0;
        case (state_q)
            IDLE: begin
                // A valid_i beat in the same cycle as start_i is dropped on purpose.
                if (start_i) begin
                    cnt_d   = '0;
                    state_d = (LANES == 1) ? STREAM : FILL;
                end
            end
            FILL: begin
                if (valid_i) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == FILL_LAST) state_d = STREAM;
                end
            end
            STREAM: begin
                if (valid_i) begin
                    cnt_d = cnt_q + CW'(1);
                    fire  = 1'b1;
                    if (cnt_q == STREAM_LAST) begin
                        fire_last = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and beat counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output registers. The row word is captured only when a row completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= fire;
            last_q  <= fire_last;
            done_q  <= fire_last;
            if (fire) word_q <= aligned;
        end
    end

    assign word_o  = word_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign done_o  = done_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Bench for systolic_output_deskew.
// The reference model keeps a queue of whole expected rows for each tile.
// Skewed beats are generated from a row/lane matrix.
module tb_systolic_output_deskew;

    localparam int DW = 16;
    localparam int L  = 8;
    localparam int R  = 8;
    localparam int WW = DW * L;
    localparam int T  = R + L - 1;   // beats per tile

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: default geometry.
    logic          rst_i, start_i, valid_i;
    logic [WW-1:0] skew_i, word_o;
    logic          valid_o, last_o, busy_o, done_o;

    systolic_output_deskew #(.DATA_WIDTH(DW), .LANES(L), .ROWS(R)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .valid_i(valid_i),
        .skew_i(skew_i), .word_o(word_o), .valid_o(valid_o), .last_o(last_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    // Boundary instance: a single row per tile.
    logic          b_rst, b_start, b_valid;
    logic [WW-1:0] b_skew, b_word;
    logic          b_valid_o, b_last, b_busy, b_done;

    systolic_output_deskew #(.DATA_WIDTH(DW), .LANES(L), .ROWS(1)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .start_i(b_start), .valid_i(b_valid),
        .skew_i(b_skew), .word_o(b_word), .valid_o(b_valid_o), .last_o(b_last),
        .busy_o(b_busy), .done_o(b_done)
    );

    // Scoreboard and model state.
    logic [WW-1:0] exp_q[$];
    logic [DW-1:0] m [R][L];
    logic [WW-1:0] exp_word;
    bit            active;
    int            k;
    int            total  = 0;
    int            passed = 0;
    int            done_cnt = 0;

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        for (int i = 0; i < WW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Fill the tile matrix and queue the expected rows in order.
    task automatic load_tile(input bit nominal, input logic [DW-1:0] ofs);
        logic [WW-1:0] w;
        for (int r = 0; r < R; r++) begin
            for (int i = 0; i < L; i++)
                m[r][i] = nominal ? (DW'((r << 8) | i) + ofs) : DW'($urandom);
            for (int i = 0; i < L; i++) w[i*DW +: DW] = m[r][i];
            exp_q.push_back(w);
        end
    endtask

    // Skewed beat kb: lane i carries row kb-i. Lanes off the diagonal get junk.
    function automatic logic [WW-1:0] beat(input int kb);
        logic [WW-1:0] w;
        w = rand_word();
        for (int i = 0; i < L; i++)
            if (kb - i >= 0 && kb - i < R) w[i*DW +: DW] = m[kb-i][i];
        return w;
    endfunction

    // One clock of stimulus. The model predicts the outputs after the edge,
    // and they are checked 1 time unit later.
    task automatic step(input logic rst, input logic st, input logic vld, input logic [WW-1:0] sk);
        logic ev, el;
        rst_i = rst; start_i = st; valid_i = vld; skew_i = sk;
        ev = 1'b0; el = 1'b0;
        if (rst) begin
            active = 0; exp_word = '0; exp_q.delete();
        end else if (!active) begin
            if (st) begin active = 1; k = 0; end
        end else if (vld) begin
            if (k >= L - 1) begin
                ev = 1'b1;
                el = (k == T - 1);
                if (exp_q.size() > 0) exp_word = exp_q.pop_front();
            end
            if (k == T - 1) active = 0;
            k++;
        end
        @(posedge clk); #1;
        if (done_o === 1'b1) done_cnt++;
        check("valid_o", valid_o, ev);
        check("last_o",  last_o,  el);
        check("done_o",  done_o,  el);
        check("busy_o",  busy_o,  active);
        check("word_o",  word_o,  exp_word);
    endtask

    // Run a full tile. Optional: stalls, a beat presented with start_i,
    // a second start_i mid-stream, random stalls, or a reset abort.
    task automatic run_tile(input bit nominal, input logic [DW-1:0] ofs, input int stall1,
                            input int stall2, input bit start_with_beat, input int restart_at,
                            input bit rand_stall, input int abort_at);
        load_tile(nominal, ofs);
        step(0, 1, start_with_beat, rand_word());
        for (int kb = 0; kb < T; kb++) begin
            step(0, (kb == restart_at), 1, beat(kb));
            if (kb == abort_at) begin
                step(1, 0, 0, '0);
                return;
            end
            if (kb == stall1 || kb == stall2) repeat (3) step(0, 0, 0, rand_word());
            if (rand_stall && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 2)) step(0, 0, 0, rand_word());
        end
    endtask

    task automatic step_b(input logic rst, input logic st, input logic vld, input logic [WW-1:0] sk);
        b_rst = rst; b_start = st; b_valid = vld; b_skew = sk;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [DW-1:0] mb [L];
        logic [WW-1:0] wb, sb;
        int d0;
        active = 0; k = 0; exp_word = '0;
        rst_i = 1; start_i = 0; valid_i = 0; skew_i = '0;
        b_rst = 1; b_start = 0; b_valid = 0; b_skew = '0;

        // Reset state.
        step(1, 1, 1, rand_word());
        step(1, 0, 0, '0);

        // Nominal tile with the recognisable r/i pattern.
        d0 = done_cnt;
        run_tile(1, '0, -1, -1, 0, -1, 0, -1);
        check("nominal_done_pulses", 32'(done_cnt - d0), 1);

        // Stalls after beats 4 and 10.
        run_tile(1, '0, 4, 10, 0, -1, 0, -1);

        // Reset mid-tile after beat 9, then a clean tile.
        run_tile(1, '0, -1, -1, 0, -1, 0, 9);
        run_tile(1, '0, -1, -1, 0, -1, 0, -1);

        // Beats in IDLE are ignored; start with a beat drops that beat;
        // a second start during STREAM is ignored.
        repeat (4) step(0, 0, 1, rand_word());
        run_tile(0, '0, -1, -1, 1, 10, 0, -1);

        // Back-to-back tiles: the second start comes right after done_o.
        d0 = done_cnt;
        run_tile(1, '0, -1, -1, 0, -1, 0, -1);
        run_tile(1, 16'h1000, -1, -1, 0, -1, 0, -1);
        check("b2b_done_pulses", 32'(done_cnt - d0), 2);

        // Random data with random stalls.
        repeat (3) run_tile(0, '0, -1, -1, 0, -1, 1, -1);
        repeat (2) step(0, 0, 0, '0);

        // ROWS=1 boundary: 8 beats give a single word with valid/last/done.
        step_b(1, 0, 0, '0);
        check("b_reset_valid", b_valid_o, 0);
        check("b_reset_word", b_word, '0);
        for (int i = 0; i < L; i++) begin
            mb[i] = DW'($urandom);
            wb[i*DW +: DW] = mb[i];
        end
        step_b(0, 1, 0, '0);
        check("b_busy_start", b_busy, 1);
        for (int kb = 0; kb < L; kb++) begin
            sb = rand_word();
            sb[kb*DW +: DW] = mb[kb];
            step_b(0, 0, 1, sb);
            if (kb < L - 1) check("b_valid_fill", b_valid_o, 0);
        end
        check("b_valid", b_valid_o, 1);
        check("b_last",  b_last, 1);
        check("b_done",  b_done, 1);
        check("b_word",  b_word, wb);
        check("b_busy_end", b_busy, 0);
        step_b(0, 0, 0, '0);
        check("b_valid_after", b_valid_o, 0);
        check("b_word_hold", b_word, wb);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/systolic_output_deskew.md
Name: systolic_output_deskew

Overview:
- Inverse of the input skewing stage; sits between the bottom/edge of the systolic array and the result write-back path.
- The array emits each result row diagonally: lane i of a row arrives i beats after lane 0.
- This block re-aligns each row into one word, tags it valid/last, and frames one tile of ROWS rows per start_i.

Parameters:
DATA_WIDTH, 16, width of one lane element.
LANES, 8, lanes per word; WORD_WIDTH = DATA_WIDTH*LANES.
ROWS, 8, result rows per tile (>=1).

Ports:
clk_i  input  1  clock; all logic on rising edge.
rst_i  input  1  synchronous, active-high reset.
start_i  input  1  one-cycle pulse that opens a tile; honoured only in IDLE.
valid_i  input  1  skew_i carries a beat this cycle; low = stall, all state holds.
skew_i  input  WORD_WIDTH  skewed beat; lane i at bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
word_o  output  WORD_WIDTH  de-skewed row, registered.
valid_o  output  1  word_o holds a complete row.
last_o  output  1  with valid_o, marks row ROWS-1.
busy_o  output  1  high in FILL/STREAM.
done_o  output  1  one-cycle pulse, coincident with last_o.

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE; all delay lines, beat counter and outputs cleared; word_o=0, valid_o=last_o=done_o=busy_o=0. Reset overrides start_i/valid_i and aborts a tile mid-stream with no partial output.
- Input timing contract: with beats numbered k=0,1,... (valid_i cycles only), lane i of row r is presented at beat r+i. A tile is exactly ROWS+LANES-1 beats. Lanes outside the diagonal are don't-care.
- Delay lines: lane i passes through a LANES-1-i stage shift register; lane LANES-1 has no delay. Stages advance only on cycles with valid_i=1 and state in FILL/STREAM. Lane i of row r is therefore at the delay-line output on beat r+LANES-1.
- Beat counter: cnt counts accepted beats, width ceil(log2(ROWS+LANES)).
- State machine:
  - IDLE: busy_o=0; valid_i is ignored. start_i moves to FILL with cnt=0.
  - FILL: accepts beats 0..LANES-2; no output. After beat LANES-2, moves to STREAM. If LANES=1, goes straight to STREAM.
  - STREAM: on each accepted beat k (LANES-1 <= k <= ROWS+LANES-2), next cycle has word_o = aligned row k-(LANES-1) and valid_o=1. After beat ROWS+LANES-2, moves to IDLE.
- Output latency: valid_o/word_o appear exactly 1 cycle after the accepting beat. valid_o=0 on any cycle not following an accepted STREAM beat; word_o holds its last value while valid_o=0.
- last_o=done_o=1 for exactly the cycle carrying row ROWS-1. busy_o drops on that same cycle.
- start_i while busy_o=1 is ignored. start_i and valid_i in the same cycle in IDLE: the start is taken and the beat is dropped (beat 0 must come later).
- A new tile may start the cycle after done_o; delay-line contents are not cleared between tiles and are not required to be.
- Stall mid-tile (valid_i=0 for any number of cycles): no shift, no count, valid_o=0. Alignment is preserved across the stall.

Test Plan:
1. Nominal (defaults): lane i of row r = 16'h{r,i} (e.g. r=2,i=5 -> 16'h0205), fed on 15 consecutive beats after start_i -> valid_o on 8 consecutive cycles starting 1 cycle after beat 7. Row 0 word_o = {0007,0006,...,0000}; row 7 = {0707,...,0700}; last_o/done_o only on row 7.
2. Stalls: same data with valid_i dropped for 3 cycles after beats 4 and 10 -> identical 8 words in order, valid_o gaps of 3 cycles, no corrupted lanes.
3. Reset mid-tile: assert rst_i after beat 9 -> next cycle all outputs 0, busy_o=0. A new start_i plus 15 beats then yields a correct tile.
4. Ignored controls: valid_i beats in IDLE produce no valid_o. A second start_i during STREAM does not restart cnt; row sequence unchanged.
5. Back-to-back tiles: start_i the cycle after done_o with a second data set (values +16'h1000) -> 16 correct rows total, exactly two done_o pulses.
6. Boundary ROWS=1, LANES=8: 8 beats -> a single word with valid_o=last_o=done_o=1 together.
